// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

   localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small FIFO of fetched {pc, instr} pairs between fetch and decode.
// Flush empties the queue and overrides any push/pop in the same cycle.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_entry,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head_entry,
   output logic [CW-1:0] count,
   output logic         full,
   output logic         empty
);

   fetch_entry_t  mem_q [DEPTH];
   fetch_entry_t  mem_d [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;

   assign full       = (count_q == CW'(DEPTH));
   assign empty      = (count_q == '0);
   assign count      = count_q;
   assign head_entry = mem_q[rd_ptr_q];
   assign do_push    = push && !full;
   assign do_pop     = pop && !empty;

   // Next-state for storage, pointers and occupancy; flush wins over push/pop.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Register storage and pointers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC ownership, word reads to instruction memory with at
// most one response outstanding, and a short queue feeding decode.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   IDLE    | reset only; leaves on the first clock after rst_n deasserts
//   REQ     | request held on imem until granted; imem_req low when the
//           | buffer is full (stall until decode pops)
//   WAIT    | one request granted, response outstanding
module fetch_stage
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_instr,
   output logic [31:0] id_pc
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          discard_q, discard_d;
   logic          redir_pend_q, redir_pend_d;
   logic [31:0]   redir_pc_q, redir_pc_d;

   fetch_entry_t  head;
   fetch_entry_t  push_entry;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] count_next;
   logic          buf_full, buf_empty;
   logic          push, pop, flush, space_next;
   logic [31:0]   redirect_target;
   logic          redirect_lsb_unused;

   // Low address bits of a redirect are meaningless for word fetches.
   assign redirect_target     = {redirect_pc[31:2], 2'b00};
   assign redirect_lsb_unused = ^redirect_pc[1:0];

   assign id_valid   = !buf_empty;
   assign id_instr   = buf_empty ? NOP_INSTR : head.instr;
   assign id_pc      = buf_empty ? 32'h0 : head.pc;
   assign imem_addr  = pc_q;

   assign pop        = id_valid && id_ready;
   assign flush      = redirect_valid;
   assign push       = (state_q == ST_WAIT) && imem_rvalid && !discard_q && !redirect_valid;
   assign push_entry = '{pc: req_pc_q, instr: imem_rdata};

   // Occupancy after this cycle decides whether a back-to-back request fits.
   assign count_next = flush ? '0 : (buf_count + CW'(push) - CW'(pop));
   assign space_next = (count_next < CW'(DEPTH));

   fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (flush),
      .head_entry (head),
      .count      (buf_count),
      .full       (buf_full),
      .empty      (buf_empty)
   );

   // Next-state, PC, discard and redirect bookkeeping; imem_req decoded here.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      req_pc_d     = req_pc_q;
      discard_d    = discard_q;
      redir_pend_d = redir_pend_q;
      redir_pc_d   = redir_pc_q;
      imem_req     = 1'b0;

      case (state_q)
         ST_IDLE: begin
            state_d = ST_REQ;
            if (redirect_valid) pc_d = redirect_target;
         end

         ST_REQ: begin
            // No response is outstanding here, so only buffer space matters;
            // occupancy cannot grow in this state, keeping the request stable.
            imem_req = !buf_full;
            if (imem_req && imem_gnt) begin
               state_d  = ST_WAIT;
               req_pc_d = pc_q;
               if (redirect_valid) begin
                  pc_d         = redirect_target;
                  discard_d    = 1'b1;
                  redir_pend_d = 1'b0;
               end else if (redir_pend_q) begin
                  pc_d         = redir_pc_q;
                  discard_d    = 1'b1;
                  redir_pend_d = 1'b0;
               end else begin
                  pc_d = next_word_pc(pc_q);
               end
            end else if (redirect_valid) begin
               if (imem_req) begin
                  // Request already on the bus: keep it, drop its data later.
                  redir_pend_d = 1'b1;
                  redir_pc_d   = redirect_target;
               end else begin
                  pc_d = redirect_target;
               end
            end
         end

         ST_WAIT: begin
            if (imem_rvalid) begin
               discard_d = 1'b0;
               if (redirect_valid) begin
                  // Response consumed now, so nothing is left to discard;
                  // the target is requested from REQ on the next cycle.
                  pc_d    = redirect_target;
                  state_d = ST_REQ;
               end else begin
                  imem_req = space_next;
                  if (imem_req && imem_gnt) begin
                     req_pc_d = pc_q;
                     pc_d     = next_word_pc(pc_q);
                  end else begin
                     state_d = ST_REQ;
                  end
               end
            end else if (redirect_valid) begin
               discard_d = 1'b1;
               pc_d      = redirect_target;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and PC registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         pc_q         <= RESET_PC;
         req_pc_q     <= RESET_PC;
         discard_q    <= 1'b0;
         redir_pend_q <= 1'b0;
         redir_pc_q   <= RESET_PC;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         req_pc_q     <= req_pc_d;
         discard_q    <= discard_d;
         redir_pend_q <= redir_pend_d;
         redir_pc_q   <= redir_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a configurable-latency memory model.
module tb_fetch_stage;
   import fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;

   logic        gnt_en;
   int          lat;
   int          mem_cnt;
   logic [31:0] mem_paddr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign imem_gnt = gnt_en;

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc)
   );

   // Memory image: word at address a holds {16'hC0DE, a[15:0]}.
   function automatic logic [31:0] img(input logic [31:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Instruction memory: response 'lat' cycles after the granting edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
         mem_cnt     <= 0;
         mem_paddr   <= 32'h0;
      end else begin
         imem_rvalid <= 1'b0;
         if (mem_cnt == 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= img(mem_paddr);
         end
         if (mem_cnt != 0) mem_cnt <= mem_cnt - 1;
         if (imem_req && imem_gnt) begin
            if (lat == 1) begin
               imem_rvalid <= 1'b1;
               imem_rdata  <= img(imem_addr);
            end else begin
               mem_cnt   <= lat - 1;
               mem_paddr <= imem_addr;
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Wait (bounded) for a valid head, check it, and let decode take it.
   task automatic pop_check(input logic [31:0] exp_pc);
      int n = 0;
      while (id_valid !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("pop_valid", {31'h0, id_valid}, 32'h1);
      chk("pop_pc", id_pc, exp_pc);
      chk("pop_instr", id_instr, img(exp_pc));
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      gnt_en         = 1'b1;
      lat            = 1;
      id_ready       = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      rst_n          = 1'b0;

      // Reset values
      repeat (2) @(negedge clk);
      chk("rst_req", {31'h0, imem_req}, 32'h0);
      chk("rst_addr", imem_addr, 32'h0000_0000);
      chk("rst_valid", {31'h0, id_valid}, 32'h0);
      chk("rst_instr", id_instr, 32'h0000_0013);
      chk("rst_pc", id_pc, 32'h0);

      // Streaming with 1-cycle memory, decode always ready
      rst_n = 1'b1;
      @(negedge clk);
      chk("e0_req", {31'h0, imem_req}, 32'h1);
      chk("e0_addr", imem_addr, 32'h0000_0000);
      chk("e0_valid", {31'h0, id_valid}, 32'h0);
      @(negedge clk);
      chk("e1_addr", imem_addr, 32'h0000_0004);
      chk("e1_valid", {31'h0, id_valid}, 32'h0);
      @(negedge clk);
      chk("e2_valid", {31'h0, id_valid}, 32'h1);
      chk("e2_pc", id_pc, 32'h0000_0000);
      chk("e2_instr", id_instr, 32'hC0DE_0000);
      chk("e2_addr", imem_addr, 32'h0000_0008);
      @(negedge clk);
      chk("e3_pc", id_pc, 32'h0000_0004);
      chk("e3_instr", id_instr, 32'hC0DE_0004);
      @(negedge clk);
      chk("e4_pc", id_pc, 32'h0000_0008);
      chk("e4_valid", {31'h0, id_valid}, 32'h1);

      // Decode back-pressure for 10 cycles
      id_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_req", {31'h0, imem_req}, 32'h0);
         chk("bp_pc", id_pc, 32'h0000_0008);
         chk("bp_valid", {31'h0, id_valid}, 32'h1);
      end
      id_ready = 1'b1;
      pop_check(32'h0000_0008);
      pop_check(32'h0000_000C);
      pop_check(32'h0000_0010);
      pop_check(32'h0000_0014);
      pop_check(32'h0000_0018);

      // Redirect while a slow response is outstanding
      lat = 3;
      n = 0;
      while (mem_cnt == 0 && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("outstanding_seen", {31'h0, mem_cnt != 0}, 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0103;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd1_valid", {31'h0, id_valid}, 32'h0);
      chk("rd1_instr", id_instr, 32'h0000_0013);
      @(negedge clk);
      chk("rd1_req", {31'h0, imem_req}, 32'h1);
      chk("rd1_addr", imem_addr, 32'h0000_0100);
      pop_check(32'h0000_0100);
      pop_check(32'h0000_0104);
      pop_check(32'h0000_0108);

      // Grant withheld; redirect while the request waits for grant
      lat = 1;
      id_ready = 1'b0;
      repeat (12) @(negedge clk);
      chk("full_req", {31'h0, imem_req}, 32'h0);
      chk("full_valid", {31'h0, id_valid}, 32'h1);
      gnt_en         = 1'b0;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0200;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd2_valid", {31'h0, id_valid}, 32'h0);
      chk("rd2_req", {31'h0, imem_req}, 32'h1);
      chk("rd2_addr", imem_addr, 32'h0000_0200);
      id_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("nognt_req", {31'h0, imem_req}, 32'h1);
         chk("nognt_addr", imem_addr, 32'h0000_0200);
      end
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0300;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("pend_req", {31'h0, imem_req}, 32'h1);
      chk("pend_addr", imem_addr, 32'h0000_0200);
      gnt_en = 1'b1;
      @(negedge clk);
      chk("pend_next_addr", imem_addr, 32'h0000_0300);
      pop_check(32'h0000_0300);
      pop_check(32'h0000_0304);

      // Redirect in the same cycle as a pop and a response
      n = 0;
      while (!(id_valid === 1'b1 && imem_rvalid === 1'b1) && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("pop_rv_seen", {31'h0, id_valid && imem_rvalid}, 32'h1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0400;
      @(negedge clk);
      redirect_valid = 1'b0;
      chk("rd3_valid", {31'h0, id_valid}, 32'h0);
      chk("rd3_instr", id_instr, 32'h0000_0013);
      chk("rd3_pc", id_pc, 32'h0);
      chk("rd3_addr", imem_addr, 32'h0000_0400);
      pop_check(32'h0000_0400);
      pop_check(32'h0000_0404);
      pop_check(32'h0000_0408);

      // Asynchronous reset mid-stream
      #2 rst_n = 1'b0;
      #1;
      chk("mrst_req", {31'h0, imem_req}, 32'h0);
      chk("mrst_addr", imem_addr, 32'h0000_0000);
      chk("mrst_valid", {31'h0, id_valid}, 32'h0);
      chk("mrst_instr", id_instr, 32'h0000_0013);
      chk("mrst_pc", id_pc, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mrst_e0_req", {31'h0, imem_req}, 32'h1);
      chk("mrst_e0_addr", imem_addr, 32'h0000_0000);
      pop_check(32'h0000_0000);
      pop_check(32'h0000_0004);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
